// File: rtl/encoder_trigger_gen_if.sv
// Signal bundle for encoder_trigger_gen.
// The master side drives the raw encoder lines and controls; the slave
// side (the generator) returns the trigger, position and status.
interface encoder_trigger_gen_if #(
  parameter int POS_W = 32
);
  logic             enc_a;
  logic             enc_b;
  logic             enc_z;
  logic             enable;
  logic [31:0]      divisor;
  logic             index_zero_en;
  logic             error_clear;
  logic             encoder_trigger;
  logic [POS_W-1:0] position;
  logic             direction;
  logic             quad_error;

  modport master (
    output enc_a, enc_b, enc_z, enable, divisor, index_zero_en, error_clear,
    input  encoder_trigger, position, direction, quad_error
  );

  modport slave (
    input  enc_a, enc_b, enc_z, enable, divisor, index_zero_en, error_clear,
    output encoder_trigger, position, direction, quad_error
  );
endinterface

// File: rtl/encoder_trigger_gen.sv
// Quadrature encoder conditioning and trigger generation.
// Pipeline: synchroniser -> glitch filter -> decode register -> apply
// register. The fixed depth makes raw-edge-to-trigger latency
// SYNC_STAGES + FILT_LEN + 2 clock edges regardless of phase history.
module encoder_trigger_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int POS_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  encoder_trigger_gen_if.slave bus
);

  localparam int              CNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  // Channel packing used throughout: bit 2 = Z, bit 1 = A, bit 0 = B.
  logic [2:0]       raw;
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       synced;
  logic [CNT_W-1:0] filt_cnt_q [3];
  logic [2:0]       filt_q;
  logic [2:0]       prev_q;
  logic             step_fwd_q;
  logic             step_bwd_q;
  logic             illegal_q;
  logic             index_q;

  logic [31:0]      phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             trig_q, trig_d;
  logic             qerr_q, qerr_d;
  logic [31:0]      div;

  assign raw = {bus.enc_z, bus.enc_a, bus.enc_b};
  assign div = bus.divisor;

  // Forward successor in the Gray sequence 00 -> 10 -> 11 -> 01 -> 00 ({A,B}).
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Multi-stage synchroniser for the three asynchronous encoder lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every stage of this array is reset so no stale level emerges as a phantom edge after release.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage samples its neighbour's pre-edge value.
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Per-channel glitch filter: level changes only after FILT_LEN differing samples in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      for (int c = 0; c < 3; c++) filt_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (synced[c] == filt_q[c]) begin
          filt_cnt_q[c] <= '0;
        end else if (filt_cnt_q[c] == CNT_MAX) begin
          filt_q[c]     <= synced[c];
          filt_cnt_q[c] <= '0;
        end else begin
          filt_cnt_q[c] <= filt_cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // Decode register: classify the filtered {A,B} change and detect index rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      step_fwd_q <= 1'b0;
      step_bwd_q <= 1'b0;
      illegal_q  <= 1'b0;
      index_q    <= 1'b0;
    end else begin
      prev_q     <= filt_q;
      step_fwd_q <= (filt_q[1:0] == fwd_next(prev_q[1:0]));
      step_bwd_q <= (prev_q[1:0] == fwd_next(filt_q[1:0]));
      illegal_q  <= ((filt_q[1:0] ^ prev_q[1:0]) == 2'b11);
      index_q    <= filt_q[2] & ~prev_q[2];
    end
  end

  // Apply stage next-state: position, direction, phase grid, trigger, sticky error.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a latch behind.
    phase_d = phase_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    trig_d  = 1'b0;
    qerr_d  = qerr_q;

    // Set takes priority over a simultaneous clear.
    if (illegal_q)            qerr_d = 1'b1;
    else if (bus.error_clear) qerr_d = 1'b0;

    if (index_q && bus.index_zero_en) begin
      // Index re-anchors the grid; any coincident step is dropped.
      pos_d   = '0;
      phase_d = '0;
    end else begin
      if (step_fwd_q) begin
        pos_d = pos_q + POS_W'(1);
        dir_d = 1'b1;
      end else if (step_bwd_q) begin
        pos_d = pos_q - POS_W'(1);
        dir_d = 1'b0;
      end

      if (!bus.enable || div == '0 || phase_q >= div) begin
        // Disabled, triggering off, or divisor shrank below the phase.
        phase_d = '0;
      end else if (step_fwd_q) begin
        if (phase_q == div - 32'd1) begin
          phase_d = '0;
          trig_d  = 1'b1;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end else if (step_bwd_q) begin
        phase_d = (phase_q == '0) ? div - 32'd1 : phase_q - 32'd1;
      end
    end
  end

  // Apply stage registers; outputs come straight from these flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      trig_q  <= 1'b0;
      qerr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      trig_q  <= trig_d;
      qerr_q  <= qerr_d;
    end
  end

  assign bus.encoder_trigger = trig_q;
  assign bus.position        = pos_q;
  assign bus.direction       = dir_q;
  assign bus.quad_error      = qerr_q;

endmodule

// File: tb/tb_encoder_trigger_gen.sv
// Directed testbench for encoder_trigger_gen (defaults: 2 sync, 4 filter).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_encoder_trigger_gen;

  logic clk = 1'b0;
  logic reset;

  encoder_trigger_gen_if #(.POS_W(32)) bus ();

  encoder_trigger_gen #(
    .SYNC_STAGES(2),
    .FILT_LEN   (4),
    .POS_W      (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks      = 0;
  int   n_fail        = 0;
  int   cyc           = 0;
  int   trig_count    = 0;
  int   last_trig_cyc = -1;
  int   width_err     = 0;
  logic trig_prev     = 1'b0;

  logic [1:0] seq [4];
  int         idx = 0;

  // Rising clock edge counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Trigger monitor: counts pulses, stamps the last one, flags pulses wider than 1 cycle.
  always @(negedge clk) begin
    if (bus.encoder_trigger === 1'b1) begin
      trig_count    <= trig_count + 1;
      last_trig_cyc <= cyc;
      if (trig_prev) width_err <= width_err + 1;
    end
    trig_prev <= bus.encoder_trigger;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Move one quadrature state (called on a falling edge); returns edges seen so far.
  task automatic drive_step(input bit fwd, output int launch);
    idx = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
    {bus.enc_a, bus.enc_b} = seq[idx];
    launch = cyc;
  endtask

  task automatic step(input bit fwd);
    int l;
    drive_step(fwd, l);
    hold(10);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.enc_z = 1'b0;
    idx       = 0;
    hold(4);
    reset = 1'b1;
    hold(2);
  endtask

  task automatic test_reset();
    reset             = 1'b0;
    bus.enc_a         = 1'b0;
    bus.enc_b         = 1'b0;
    bus.enc_z         = 1'b0;
    bus.enable        = 1'b0;
    bus.divisor       = 32'd0;
    bus.index_zero_en = 1'b0;
    bus.error_clear   = 1'b0;
    hold(3);
    n_checks++; if (bus.encoder_trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger: got %b expected 0", bus.encoder_trigger); end
    n_checks++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL reset_position: got %0d expected 0", bus.position); end
    n_checks++; if (bus.direction !== 1'b1) begin n_fail++; $display("FAIL reset_direction: got %b expected 1", bus.direction); end
    n_checks++; if (bus.quad_error !== 1'b0) begin n_fail++; $display("FAIL reset_quad_error: got %b expected 0", bus.quad_error); end
    reset = 1'b1;
    hold(5);
    n_checks++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL release_position: got %0d expected 0", bus.position); end
    n_checks++; if (trig_count !== 0) begin n_fail++; $display("FAIL release_triggers: got %0d expected 0", trig_count); end
  endtask

  task automatic test_forward();
    int launch;
    int base;
    bus.divisor = 32'd4;
    bus.enable  = 1'b1;
    apply_reset();
    base = trig_count;
    for (int k = 1; k <= 16; k++) begin
      drive_step(1'b1, launch);
      hold(10);
      if (k % 4 == 0) begin
        n_checks++;
        if (last_trig_cyc - launch !== 8) begin
          n_fail++;
          $display("FAIL fwd_latency_step%0d: got %0d expected 8", k, last_trig_cyc - launch);
        end
      end
    end
    n_checks++; if (trig_count - base !== 4) begin n_fail++; $display("FAIL fwd_trigger_count: got %0d expected 4", trig_count - base); end
    n_checks++; if (bus.position !== 32'd16) begin n_fail++; $display("FAIL fwd_position: got %0d expected 16", bus.position); end
    n_checks++; if (bus.direction !== 1'b1) begin n_fail++; $display("FAIL fwd_direction: got %b expected 1", bus.direction); end
    n_checks++; if (width_err !== 0) begin n_fail++; $display("FAIL fwd_pulse_width: got %0d wide pulses expected 0", width_err); end
  endtask

  task automatic test_fwd_bwd();
    int base;
    bus.divisor = 32'd4;
    apply_reset();
    base = trig_count;
    for (int k = 0; k < 3; k++) step(1'b1);
    for (int k = 0; k < 3; k++) step(1'b0);
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL fb_no_trigger_backward: got %0d expected 0", trig_count - base); end
    n_checks++; if (bus.direction !== 1'b0) begin n_fail++; $display("FAIL fb_direction_back: got %b expected 0", bus.direction); end
    for (int k = 0; k < 3; k++) step(1'b1);
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL fb_before_step4: got %0d expected 0", trig_count - base); end
    step(1'b1);
    n_checks++; if (trig_count - base !== 1) begin n_fail++; $display("FAIL fb_on_step4: got %0d expected 1", trig_count - base); end
    step(1'b1);
    n_checks++; if (trig_count - base !== 1) begin n_fail++; $display("FAIL fb_total: got %0d expected 1", trig_count - base); end
    n_checks++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL fb_position: got %0d expected 5", bus.position); end
    n_checks++; if (bus.direction !== 1'b1) begin n_fail++; $display("FAIL fb_direction: got %b expected 1", bus.direction); end
  endtask

  task automatic test_glitch_error();
    int base;
    base = trig_count;
    bus.enc_a = ~bus.enc_a;
    hold(3);
    bus.enc_a = ~bus.enc_a;
    hold(10);
    n_checks++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL glitch_position: got %0d expected 5", bus.position); end
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL glitch_trigger: got %0d expected 0", trig_count - base); end
    n_checks++; if (bus.quad_error !== 1'b0) begin n_fail++; $display("FAIL glitch_quad_error: got %b expected 0", bus.quad_error); end
    idx = (idx + 2) % 4;
    {bus.enc_a, bus.enc_b} = seq[idx];
    hold(10);
    n_checks++; if (bus.quad_error !== 1'b1) begin n_fail++; $display("FAIL illegal_quad_error: got %b expected 1", bus.quad_error); end
    n_checks++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL illegal_position: got %0d expected 5", bus.position); end
    bus.error_clear = 1'b1;
    hold(1);
    bus.error_clear = 1'b0;
    hold(2);
    n_checks++; if (bus.quad_error !== 1'b0) begin n_fail++; $display("FAIL error_clear: got %b expected 0", bus.quad_error); end
  endtask

  task automatic test_index();
    int base;
    int l;
    bus.divisor = 32'd0;
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b1);
    bus.divisor = 32'd5;
    for (int k = 0; k < 3; k++) step(1'b1);
    n_checks++; if (bus.position !== 32'd7) begin n_fail++; $display("FAIL index_setup_position: got %0d expected 7", bus.position); end
    base = trig_count;
    bus.index_zero_en = 1'b1;
    bus.enc_z = 1'b1;
    drive_step(1'b1, l);
    hold(10);
    n_checks++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL index_position: got %0d expected 0", bus.position); end
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL index_trigger: got %0d expected 0", trig_count - base); end
    for (int k = 0; k < 4; k++) step(1'b1);
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL index_after4: got %0d expected 0", trig_count - base); end
    step(1'b1);
    n_checks++; if (trig_count - base !== 1) begin n_fail++; $display("FAIL index_after5: got %0d expected 1", trig_count - base); end
    n_checks++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL index_final_position: got %0d expected 5", bus.position); end
    bus.enc_z = 1'b0;
    bus.index_zero_en = 1'b0;
    hold(10);
  endtask

  task automatic test_divisor_enable();
    int base;
    bus.divisor = 32'd0;
    bus.enable  = 1'b1;
    apply_reset();
    base = trig_count;
    for (int k = 0; k < 20; k++) step(1'b1);
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL div0_triggers: got %0d expected 0", trig_count - base); end
    n_checks++; if (bus.position !== 32'd20) begin n_fail++; $display("FAIL div0_position: got %0d expected 20", bus.position); end
    bus.divisor = 32'd1;
    for (int k = 0; k < 3; k++) step(1'b1);
    n_checks++; if (trig_count - base !== 3) begin n_fail++; $display("FAIL div1_triggers: got %0d expected 3", trig_count - base); end
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b1);
    n_checks++; if (bus.position !== 32'd33) begin n_fail++; $display("FAIL disabled_position: got %0d expected 33", bus.position); end
    n_checks++; if (trig_count - base !== 3) begin n_fail++; $display("FAIL disabled_triggers: got %0d expected 3", trig_count - base); end
    bus.divisor = 32'd4;
    bus.enable  = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1);
    n_checks++; if (trig_count - base !== 3) begin n_fail++; $display("FAIL reenable_first3: got %0d expected 3", trig_count - base); end
    step(1'b1);
    n_checks++; if (trig_count - base !== 4) begin n_fail++; $display("FAIL reenable_step4: got %0d expected 4", trig_count - base); end
  endtask

  task automatic test_reset_midop();
    int base;
    int l;
    bus.divisor = 32'd1;
    bus.enable  = 1'b1;
    apply_reset();
    step(1'b1);
    step(1'b1);
    idx = (idx + 2) % 4;
    {bus.enc_a, bus.enc_b} = seq[idx];
    hold(10);
    n_checks++; if (bus.quad_error !== 1'b1) begin n_fail++; $display("FAIL midop_setup_error: got %b expected 1", bus.quad_error); end
    n_checks++; if (bus.position !== 32'd2) begin n_fail++; $display("FAIL midop_setup_position: got %0d expected 2", bus.position); end
    drive_step(1'b1, l);
    hold(7);
    base = trig_count;
    reset     = 1'b0;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    idx       = 0;
    #1;
    n_checks++; if (bus.encoder_trigger !== 1'b0) begin n_fail++; $display("FAIL midop_trigger: got %b expected 0", bus.encoder_trigger); end
    n_checks++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL midop_position: got %0d expected 0", bus.position); end
    n_checks++; if (bus.quad_error !== 1'b0) begin n_fail++; $display("FAIL midop_quad_error: got %b expected 0", bus.quad_error); end
    hold(4);
    n_checks++; if (trig_count - base !== 0) begin n_fail++; $display("FAIL midop_aborted: got %0d expected 0", trig_count - base); end
    reset = 1'b1;
    hold(2);
    step(1'b1);
    n_checks++; if (trig_count - base !== 1) begin n_fail++; $display("FAIL resume_trigger: got %0d expected 1", trig_count - base); end
    n_checks++; if (bus.position !== 32'd1) begin n_fail++; $display("FAIL resume_position: got %0d expected 1", bus.position); end
  endtask

  initial begin
    seq[0] = 2'b00;
    seq[1] = 2'b10;
    seq[2] = 2'b11;
    seq[3] = 2'b01;
    test_reset();
    test_forward();
    test_fwd_bwd();
    test_glitch_error();
    test_index();
    test_divisor_enable();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
